pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Pipeline sequencer and single-port RAM arbiter for the 5-stage CPU. Shares one SRAM port between
//  instruction fetch (IF) and the MEM stage, and drives stall/bubble/flush controls for the PC and
//  the IF_ID, ID_EX, EX_MEM and MEM_WB stage registers. Also covers load-use hazards and taken branches.
// PARAMETERS
//  RAM_WAIT  1   extra wait cycles per RAM access; each access takes RAM_WAIT+1 cycles (range 0..7)
// PORTS
//  clk_50MHz     in  1   system clock; all state updates on rising edge
//  rst           in  1   reset, synchronous, active-high
//  if_req        in  1   IF stage requests an instruction fetch at if_addr
//  if_addr       in  16  fetch address; latched when the fetch starts
//  mem_rd        in  1   MEM stage load request (from EX_MEM)
//  mem_wr        in  1   MEM stage store request (from EX_MEM); mem_rd and mem_wr are never both high
//  mem_addr      in  16  data address; latched when the access starts
//  mem_wdata     in  16  store data; latched when the access starts
//  ram_rdata     in  16  SRAM read data, valid on the last cycle of an access
//  ram_addr      out 16  SRAM address
//  ram_wdata     out 16  SRAM write data
//  ram_oe        out 1   SRAM read enable
//  ram_we        out 1   SRAM write enable
//  if_inst       out 16  fetched instruction, held until the next fetch completes
//  if_valid      out 1   one-cycle pulse: if_inst was updated with a non-killed fetch
//  mem_rdata     out 16  load data (to MEM_WB), held until the next load completes
//  id_rs_en      in  1   ID instruction reads rs
//  id_rt_en      in  1   ID instruction reads rt
//  id_rs_addr    in  4   rs register address
//  id_rt_addr    in  4   rt register address
//  ex_load       in  1   EX instruction is a load
//  ex_wb_addr    in  4   EX instruction destination register
//  branch_taken  in  1   ID resolves a taken branch or jump this cycle
//  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem   out 1 each; hold that register
//  bubble_id_ex, bubble_mem_wb                        out 1 each; load a NOP into that register
//  flush_if_id   out 1   load NOP (0x0800) into IF_ID
//  perf_mem_stall, perf_lu_stall   out 16 each; performance counters (see CONFIGURATION)
// BEHAVIOUR
//  FSM states: S_IDLE, S_DATA, S_INST. Wait counter cnt is 3 bits and cleared on every state entry.
//  RAM outputs are decoded from registered state only (Moore); an access begins the cycle after entry.
//  S_IDLE: if mem_rd|mem_wr, go to S_DATA and latch mem_addr, mem_wdata and the direction.
//          Otherwise, if if_req, go to S_INST and latch if_addr. MEM always has priority over IF.
//  S_DATA: ram_addr = latched address. ram_oe=1 for a read; ram_we=1 and ram_wdata=latched data for a write.
//          cnt increments each cycle; mem_done = (cnt==RAM_WAIT).
//          On mem_done a read captures mem_rdata<=ram_rdata. Next state is S_INST if if_req, else S_IDLE.
//  S_INST: ram_oe=1 and ram_addr = latched if_addr; if_done = (cnt==RAM_WAIT).
//          On if_done: if_inst<=ram_rdata, and if_valid pulses unless kill=1.
//          Next state is S_DATA if a MEM request is present (latched as in S_IDLE), else S_IDLE.
//          An in-flight fetch is never aborted.
//  Hazard terms, combinational:
//   mem_stall = (mem_rd|mem_wr) & ~mem_done
//   if_stall  = if_req & ~if_done
//   lu = ex_load & ((id_rs_en & ex_wb_addr==id_rs_addr) | (id_rt_en & ex_wb_addr==id_rt_addr))
//  Control outputs:
//   stall_ex_mem = stall_id_ex = bubble_mem_wb = mem_stall
//   stall_if_id  = mem_stall | lu;  bubble_id_ex = lu & ~mem_stall
//   br  = branch_taken & ~mem_stall & ~lu   (branch accepted)
//   stall_pc     = mem_stall | lu | (if_stall & ~br)   (an accepted branch always updates the PC)
//   flush_if_id  = ~mem_stall & ~lu & (br | if_stall | (if_done & kill))
//  kill register: set when br occurs while in S_INST before if_done; cleared on if_done.
//  If br occurs on the if_done cycle itself, that instruction is flushed by br.
//  Reset values: state=S_IDLE, cnt=0, kill=0, if_inst=0x0800, if_valid=0, mem_rdata=0x0000.
//  ram_oe=ram_we=0 and ram_addr=ram_wdata=0x0000 in S_IDLE.
//  Reset mid-access abandons the access; ram_we drops in the first cycle after the reset edge.
// CONFIGURATION
//  PIPELINE_PERF_CNT_EN defined:
//   - perf_mem_stall increments on every cycle with mem_stall=1.
//   - perf_lu_stall increments on every cycle with lu & ~mem_stall.
//   - Both counters are 16-bit, wrap 0xFFFF->0x0000, and are cleared by rst.
//  Not defined: both ports are tied to 0x0000 and no counter flops exist.
// TESTING
//  1) RAM_WAIT=1, IF only, if_addr=0x0010, RAM returns 0x4A01 -> ram_oe 2 cycles, stall_pc 2 cycles,
//     if_valid pulses once, if_inst=0x4A01.
//  2) mem_rd and if_req both high from S_IDLE, mem_addr=0x8000 -> S_DATA first.
//     mem_stall/bubble_mem_wb for 2 cycles, mem_rdata=RAM value, then S_INST.
//  3) mem_wr with mem_addr=0x8004, mem_wdata=0xBEEF -> ram_we=1 for exactly RAM_WAIT+1 cycles,
//     ram_wdata=0xBEEF, ram_oe=0 throughout.
//  4) ex_load=1, ex_wb_addr=3, id_rt_en=1, id_rt_addr=3, no MEM request -> one cycle of
//     stall_pc, stall_if_id and bubble_id_ex; with ex_wb_addr=4 -> none asserted.
//  5) branch_taken mid-fetch in S_INST -> stall_pc=0 that cycle, kill=1,
//     on if_done if_valid=0 and flush_if_id=1.
//  6) rst=1 during an S_DATA write -> next cycle state=S_IDLE, ram_we=0, if_inst=0x0800;
//     with PIPELINE_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Memory-side bus of the pipeline sequencer: IF fetch request, MEM load/store
// request, and the shared single-port SRAM. The slave modport is the
// sequencer itself; the master modport is its environment (pipeline + SRAM).
interface pipeline_ctrl_if;
    // IF stage fetch
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_inst;
    logic        if_valid;
    // MEM stage load/store
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    // shared SRAM port
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_oe;
    logic        ram_we;

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        input  if_inst, if_valid, mem_rdata, ram_addr, ram_wdata, ram_oe, ram_we
    );

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        output if_inst, if_valid, mem_rdata, ram_addr, ram_wdata, ram_oe, ram_we
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer and single-port SRAM arbiter for the 5-stage CPU.
// MEM accesses win over instruction fetches; each access lasts RAM_WAIT+1
// cycles and the SRAM strobes are decoded from registered state only.
// Optional feature: define PIPELINE_PERF_CNT_EN to build the two 16-bit
// stall performance counters; otherwise both counter ports read 0x0000.
module pipeline_ctrl #(
    parameter int unsigned RAM_WAIT = 1   // extra wait cycles per access, 0..7
) (
    input  logic                 clk_50MHz,
    input  logic                 rst,
    pipeline_ctrl_if.slave       bus,
    input  logic                 id_rs_en,
    input  logic                 id_rt_en,
    input  logic [3:0]           id_rs_addr,
    input  logic [3:0]           id_rt_addr,
    input  logic                 ex_load,
    input  logic [3:0]           ex_wb_addr,
    input  logic                 branch_taken,
    output logic                 stall_pc,
    output logic                 stall_if_id,
    output logic                 stall_id_ex,
    output logic                 stall_ex_mem,
    output logic                 bubble_id_ex,
    output logic                 bubble_mem_wb,
    output logic                 flush_if_id,
    output logic [15:0]          perf_mem_stall,
    output logic [15:0]          perf_lu_stall
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST} state_t;

    localparam logic [2:0]  WAIT_LAST = RAM_WAIT[2:0];
    localparam logic [15:0] NOP_INST  = 16'h0800;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        d_we_q, d_we_d;          // latched MEM direction: 1 = store
    logic [15:0] d_addr_q, d_addr_d;
    logic [15:0] d_wdata_q, d_wdata_d;
    logic [15:0] f_addr_q, f_addr_d;
    logic [15:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;

    logic mem_req;
    logic mem_done;
    logic if_done;
    logic mem_stall;
    logic if_stall;
    logic lu;
    logic br;

    assign mem_req  = bus.mem_rd | bus.mem_wr;
    assign mem_done = (state_q == S_DATA) && (cnt_q == WAIT_LAST);
    assign if_done  = (state_q == S_INST) && (cnt_q == WAIT_LAST);

    // Hazard terms and pipeline register controls
    always_comb begin
        mem_stall = mem_req & ~mem_done;
        if_stall  = bus.if_req & ~if_done;
        lu        = ex_load & ((id_rs_en & (ex_wb_addr == id_rs_addr)) |
                               (id_rt_en & (ex_wb_addr == id_rt_addr)));
        br        = branch_taken & ~mem_stall & ~lu;

        stall_ex_mem  = mem_stall;
        stall_id_ex   = mem_stall;
        bubble_mem_wb = mem_stall;
        stall_if_id   = mem_stall | lu;
        bubble_id_ex  = lu & ~mem_stall;
        // an accepted branch always redirects the PC, even mid-fetch
        stall_pc      = mem_stall | lu | (if_stall & ~br);
        flush_if_id   = ~mem_stall & ~lu & (br | if_stall | (if_done & kill_q));
    end

    // Arbiter next-state, request latching and result capture
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latch).
        state_d     = state_q;
        d_we_d      = d_we_q;
        d_addr_d    = d_addr_q;
        d_wdata_d   = d_wdata_q;
        f_addr_d    = f_addr_q;
        if_inst_d   = if_inst_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    state_d   = S_DATA;
                    d_we_d    = bus.mem_wr;
                    d_addr_d  = bus.mem_addr;
                    d_wdata_d = bus.mem_wdata;
                end else if (bus.if_req) begin
                    state_d  = S_INST;
                    f_addr_d = bus.if_addr;
                end
            end
            S_DATA: begin
                if (mem_done) begin
                    if (!d_we_q) mem_rdata_d = bus.ram_rdata;
                    if (bus.if_req) begin
                        state_d  = S_INST;
                        f_addr_d = bus.if_addr;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_INST: begin
                // a fetch in flight always runs to completion
                if (if_done) begin
                    if_inst_d  = bus.ram_rdata;
                    if_valid_d = ~kill_q;
                    if (mem_req) begin
                        state_d   = S_DATA;
                        d_we_d    = bus.mem_wr;
                        d_addr_d  = bus.mem_addr;
                        d_wdata_d = bus.mem_wdata;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // wait counter restarts on every state entry
        if (state_d != state_q || state_q == S_IDLE) cnt_d = 3'd0;
        else                                         cnt_d = cnt_q + 3'd1;

        // a branch accepted mid-fetch marks that fetch as wrong-path
        if (if_done)                          kill_d = 1'b0;
        else if (br && state_q == S_INST)     kill_d = 1'b1;
        else                                  kill_d = kill_q;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_50MHz) begin
        // NOTE: sequential state uses <= so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            kill_q      <= 1'b0;
            d_we_q      <= 1'b0;
            d_addr_q    <= 16'h0000;
            d_wdata_q   <= 16'h0000;
            f_addr_q    <= 16'h0000;
            if_inst_q   <= NOP_INST;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            d_we_q      <= d_we_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            f_addr_q    <= f_addr_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // SRAM strobes decoded from registered state only (Moore)
    always_comb begin
        bus.ram_addr  = 16'h0000;
        bus.ram_wdata = 16'h0000;
        bus.ram_oe    = 1'b0;
        bus.ram_we    = 1'b0;
        unique case (state_q)
            S_DATA: begin
                bus.ram_addr = d_addr_q;
                if (d_we_q) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_wdata = d_wdata_q;
                end else begin
                    bus.ram_oe = 1'b1;
                end
            end
            S_INST: begin
                bus.ram_addr = f_addr_q;
                bus.ram_oe   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.if_inst   = if_inst_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.mem_rdata = mem_rdata_q;

`ifdef PIPELINE_PERF_CNT_EN
    logic [15:0] perf_mem_q, perf_mem_d;
    logic [15:0] perf_lu_q, perf_lu_d;

    // Stall counters, wrapping at 16 bits
    always_comb begin
        perf_mem_d = perf_mem_q + (mem_stall ? 16'd1 : 16'd0);
        perf_lu_d  = perf_lu_q + ((lu & ~mem_stall) ? 16'd1 : 16'd0);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            perf_mem_q <= 16'h0000;
            perf_lu_q  <= 16'h0000;
        end else begin
            perf_mem_q <= perf_mem_d;
            perf_lu_q  <= perf_lu_d;
        end
    end

    assign perf_mem_stall = perf_mem_q;
    assign perf_lu_stall  = perf_lu_q;
`else
    assign perf_mem_stall = 16'h0000;
    assign perf_lu_stall  = 16'h0000;
`endif

endmodule
